mito_feeder: RTL and testbench

Host-side transmitter for the MITO accelerator's load interface. Host words are buffered in an internal FIFO. On a launch command the block pulses `start` and then streams a fixed number of 32-bit words onto the accelerator input bus, one word per cycle. It then waits for the accelerator's `ready_finish` and reports completion. It sits between the host/testbench memory port and the accelerator top's `start`/`MITO_input` pins.

---
 rtl/mito_feeder.sv | 235 +++++++++++++++++++++++
 tb/tb_mito_feeder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mito_feeder.sv
// -----------------------------------------------------------------------------
// mito_feeder
//
// Host-side transmitter for the MITO accelerator load interface. Host words
// are queued in an internal FIFO. A launch command pulses start and then
// streams launch_len words onto mito_input, one per cycle. The block then
// waits for mito_ready_finish and pulses done.
//
// Optional feature macro: MITO_FEEDER_TIMEOUT_EN
//   When defined, a watchdog limits the time spent waiting for
//   mito_ready_finish to TIMEOUT_CYCLES cycles and pulses timeout on expiry.
//   When undefined, timeout is tied to 0 and the wait is unbounded.
//
// Ports
//   clk               : clock, rising edge
//   rst               : asynchronous active-high reset
//   host_wr_valid     : host word valid
//   host_wr_data      : host word
//   host_wr_ready     : FIFO not full (registered)
//   launch            : one-cycle transfer request (honoured in IDLE only)
//   launch_len        : number of words to stream, sampled with launch
//   busy              : state is not IDLE
//   start             : one-cycle start pulse to the accelerator
//   mito_input        : signed stream word to the accelerator
//   mito_valid        : mito_input carries a fresh word this cycle
//   mito_ready_finish : accelerator completion (observed in WAIT only)
//   done              : one-cycle completion pulse
//   underrun          : sticky, FIFO ran empty mid-stream
//   timeout           : one-cycle watchdog pulse
// -----------------------------------------------------------------------------
module mito_feeder #(
    parameter int WORD_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         host_wr_valid,
    input  logic        [WORD_WIDTH-1:0] host_wr_data,
    output logic                         host_wr_ready,
    input  logic                         launch,
    input  logic        [LEN_WIDTH-1:0]  launch_len,
    output logic                         busy,
    output logic                         start,
    output logic signed [WORD_WIDTH-1:0] mito_input,
    output logic                         mito_valid,
    input  logic                         mito_ready_finish,
    output logic                         done,
    output logic                         underrun,
    output logic                         timeout
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]          DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_STREAM,
        ST_WAIT
    } state_t;

    // FIFO storage and control
    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic [AW:0]           w_count_nxt;
    logic                  r_wr_ready;
    logic                  w_wr;
    logic                  w_rd;

    // Sequencer state and registered outputs
    state_t                       r_state;
    logic        [LEN_WIDTH-1:0]  r_remain;
    logic                         r_busy;
    logic                         r_start;
    logic signed [WORD_WIDTH-1:0] r_mito_input;
    logic                         r_mito_valid;
    logic                         r_done;
    logic                         r_underrun;

`ifdef MITO_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] r_wd_cnt;
    logic          r_timeout;
`else
    // The watchdog limit has no effect in this build.
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    assign w_wr = host_wr_valid && r_wr_ready;
    // The first word is fetched while start is high so that it is on the
    // bus the cycle after start.
    assign w_rd = ((r_state == ST_START) || (r_state == ST_STREAM)) &&
                  (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr && !w_rd) begin
            w_count_nxt = r_count + 1'b1;
        end else if (!w_wr && w_rd) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= host_wr_data;
        end
    end

    // FIFO pointers, occupancy and registered ready. Ready is derived from
    // the next occupancy, so a read while full frees space one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_wr_ready <= 1'b1;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count    <= w_count_nxt;
            r_wr_ready <= (w_count_nxt != DEPTH_C);
        end
    end

    // Transfer sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_remain     <= '0;
            r_busy       <= 1'b0;
            r_start      <= 1'b0;
            r_mito_input <= '0;
            r_mito_valid <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef MITO_FEEDER_TIMEOUT_EN
            r_wd_cnt     <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_start      <= 1'b0;
            r_done       <= 1'b0;
            r_mito_valid <= 1'b0;
`ifdef MITO_FEEDER_TIMEOUT_EN
            r_timeout    <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (launch) begin
                        if (launch_len == '0) begin
                            // Empty transfer completes without touching
                            // the accelerator.
                            r_done <= 1'b1;
                        end else begin
                            r_remain   <= launch_len;
                            r_underrun <= 1'b0;
                            r_start    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_START;
                        end
                    end
                end

                ST_START, ST_STREAM: begin
                    if (w_rd) begin
                        r_mito_input <= r_mem[r_rd_ptr];
                        r_mito_valid <= 1'b1;
                        r_remain     <= r_remain - 1'b1;
                        if (r_remain == LEN_ONE) begin
                            r_state <= ST_WAIT;
`ifdef MITO_FEEDER_TIMEOUT_EN
                            r_wd_cnt <= '0;
`endif
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end else begin
                        // Starved: hold the last word, flag it, keep going.
                        r_underrun <= 1'b1;
                        r_state    <= ST_STREAM;
                    end
                end

                ST_WAIT: begin
                    if (mito_ready_finish) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
`ifdef MITO_FEEDER_TIMEOUT_EN
                    else if (r_wd_cnt == TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_wr_ready = r_wr_ready;
    assign busy          = r_busy;
    assign start         = r_start;
    assign mito_input    = r_mito_input;
    assign mito_valid    = r_mito_valid;
    assign done          = r_done;
    assign underrun      = r_underrun;
`ifdef MITO_FEEDER_TIMEOUT_EN
    assign timeout       = r_timeout;
`else
    assign timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_mito_feeder.sv
module tb_mito_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic               host_wr_valid;
    logic [31:0]        host_wr_data;
    logic               host_wr_ready;
    logic               launch;
    logic [15:0]        launch_len;
    logic               busy;
    logic               start;
    logic signed [31:0] mito_input;
    logic               mito_valid;
    logic               mito_ready_finish;
    logic               done;
    logic               underrun;
    logic               timeout;

    int total = 0;
    int bad   = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    mito_feeder #(
        .WORD_WIDTH    (32),
        .FIFO_DEPTH    (16),
        .LEN_WIDTH     (16),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_wr_valid    (host_wr_valid),
        .host_wr_data     (host_wr_data),
        .host_wr_ready    (host_wr_ready),
        .launch           (launch),
        .launch_len       (launch_len),
        .busy             (busy),
        .start            (start),
        .mito_input       (mito_input),
        .mito_valid       (mito_valid),
        .mito_ready_finish(mito_ready_finish),
        .done             (done),
        .underrun         (underrun),
        .timeout          (timeout)
    );

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck want=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic do_reset;
        rst = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_data = '0;
        launch = 1'b0;
        launch_len = '0;
        mito_ready_finish = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One host write cycle; the model accepts it while fewer than 16 queued.
    task automatic wr(input logic [31:0] d);
        host_wr_valid = 1'b1;
        host_wr_data = d;
        if (q.size() < 16) q.push_back(d);
        @(negedge clk);
        host_wr_valid = 1'b0;
    endtask

    // Launch sampled at cycle T; returns at the negedge of cycle T+1.
    task automatic do_launch(input int len);
        launch = 1'b1;
        launch_len = 16'(len);
        @(negedge clk);
        launch = 1'b0;
        launch_len = '0;
    endtask

    task automatic test_reset;
        do_reset();
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b want=1", host_wr_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start got=%0b want=0", start); end
        total++; if (mito_input !== 32'sd0) begin bad++; $display("FAIL rst_input got=%0h want=0", mito_input); end
        total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", mito_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b want=0", done); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL rst_underrun got=%0b want=0", underrun); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%0b want=0", timeout); end
    endtask

    task automatic test_basic;
        logic [31:0] exp;
        do_reset();
        wr(32'h11); wr(32'h22); wr(32'h33);
        do_launch(3);
        total++; if (start !== 1'b1) begin bad++; $display("FAIL basic_start got=%0b want=1", start); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b want=1", busy); end
        total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_t1 got=%0b want=0", mito_valid); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = q.pop_front();
            total++; if (mito_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_w%0d got=%0b want=1", k, mito_valid); end
            total++; if (mito_input !== exp) begin bad++; $display("FAIL basic_word%0d got=%0h want=%0h", k, mito_input, exp); end
            total++; if (start !== 1'b0) begin bad++; $display("FAIL basic_start_w%0d got=%0b want=0", k, start); end
        end
        for (int c = 5; c <= 6; c++) begin
            @(negedge clk);
            total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_t%0d got=%0b want=0", c, mito_valid); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_t%0d got=%0b want=0", c, done); end
        end
        @(negedge clk);
        mito_ready_finish = 1'b1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_wait got=%0b want=1", busy); end
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b want=1", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b want=0", busy); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL basic_underrun got=%0b want=0", underrun); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%0b want=0", done); end
    endtask

    task automatic test_full;
        logic [31:0] exp;
        int got;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            total++; if (host_wr_ready !== (q.size() != 16)) begin bad++; $display("FAIL full_ready_%0d got=%0b want=%0b", i, host_wr_ready, (q.size() != 16)); end
            wr(32'hA0 + 32'(i));
        end
        total++; if (host_wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready_after got=%0b want=0", host_wr_ready); end
        do_launch(16);
        got = 0;
        for (int c = 0; c < 40 && got < 16; c++) begin
            @(negedge clk);
            if (mito_valid) begin
                exp = q.pop_front();
                total++; if (mito_input !== exp) begin bad++; $display("FAIL full_word%0d got=%0h want=%0h", got, mito_input, exp); end
                got++;
            end
        end
        total++; if (got !== 16) begin bad++; $display("FAIL full_count got=%0d want=16", got); end
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_drained got=%0b want=1", host_wr_ready); end
        mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL full_done got=%0b want=1", done); end
        // The rejected 17th word must not be in the FIFO.
        do_launch(1);
        @(negedge clk);
        total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL full_extra_valid got=%0b want=0", mito_valid); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL full_extra_underrun got=%0b want=1", underrun); end
    endtask

    task automatic test_underrun;
        logic [31:0] exp;
        int got;
        int gaps;
        do_reset();
        wr(32'hC001); wr(32'hC002);
        do_launch(4);
        got = 0;
        gaps = 0;
        for (int c = 1; c < 40 && got < 4; c++) begin
            if (mito_valid) begin
                exp = q.pop_front();
                total++; if (mito_input !== exp) begin bad++; $display("FAIL und_word%0d got=%0h want=%0h", got, mito_input, exp); end
                got++;
            end else if (got > 0) begin
                gaps++;
            end
            if (c == 3 || c == 4) begin
                host_wr_valid = 1'b1;
                host_wr_data = 32'hC000 + 32'(c);
                q.push_back(host_wr_data);
            end else begin
                host_wr_valid = 1'b0;
            end
            @(negedge clk);
        end
        host_wr_valid = 1'b0;
        total++; if (got !== 4) begin bad++; $display("FAIL und_count got=%0d want=4", got); end
        total++; if (gaps !== 1) begin bad++; $display("FAIL und_gaps got=%0d want=1", gaps); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL und_flag got=%0b want=1", underrun); end
        mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL und_done got=%0b want=1", done); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL und_sticky got=%0b want=1", underrun); end
        wr(32'hC0FF);
        do_launch(1);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL und_cleared got=%0b want=0", underrun); end
        @(negedge clk);
        exp = q.pop_front();
        total++; if (mito_valid !== 1'b1 || mito_input !== exp) begin bad++; $display("FAIL und_next_word got=%0h want=%0h", mito_input, exp); end
        mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL und_next_done got=%0b want=1", done); end
    endtask

    task automatic test_edge;
        logic [31:0] exp;
        do_reset();
        do_launch(0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL edge_len0_done got=%0b want=1", done); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL edge_len0_start got=%0b want=0", start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL edge_len0_busy got=%0b want=0", busy); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL edge_len0_once got=%0b want=0", done); end
        wr(32'h55);
        do_launch(1);
        total++; if (start !== 1'b1) begin bad++; $display("FAIL edge_start got=%0b want=1", start); end
        // Launch and finish during START must both be ignored.
        launch = 1'b1; launch_len = 16'd5; mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        exp = q.pop_front();
        total++; if (mito_valid !== 1'b1 || mito_input !== exp) begin bad++; $display("FAIL edge_word got=%0h want=%0h", mito_input, exp); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL edge_start_once got=%0b want=0", start); end
        launch_len = 16'd2;
        @(negedge clk);
        launch = 1'b0; launch_len = '0;
        for (int c = 0; c < 3; c++) begin
            total++; if (start !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL edge_busy_%0d got=s%0b/b%0b/d%0b want=s0/b1/d0", c, start, busy, done); end
            @(negedge clk);
        end
        mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL edge_done got=d%0b/b%0b want=d1/b0", done, busy); end
        @(negedge clk);
        total++; if (start !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL edge_no_relaunch got=s%0b/b%0b want=s0/b0", start, busy); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        wr(32'h1); wr(32'h2); wr(32'h3); wr(32'h4);
        do_launch(4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b want=0", busy); end
        total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%0b want=0", mito_valid); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL rmid_start got=%0b want=0", start); end
        total++; if (host_wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%0b want=1", host_wr_ready); end
        total++; if (mito_input !== 32'sd0) begin bad++; $display("FAIL rmid_input got=%0h want=0", mito_input); end
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_no_resume got=%0b want=0", busy); end
        do_launch(1);
        @(negedge clk);
        total++; if (mito_valid !== 1'b0) begin bad++; $display("FAIL rmid_flushed_valid got=%0b want=0", mito_valid); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL rmid_flushed_underrun got=%0b want=1", underrun); end
    endtask

    task automatic test_timeout;
        logic [31:0] exp;
        int tmo;
        int first;
        int dn;
        do_reset();
        wr(32'h66);
        do_launch(1);
        tmo = 0; first = -1; dn = 0;
        for (int c = 2; c <= 30; c++) begin
            @(negedge clk);
            if (mito_valid) begin
                exp = q.pop_front();
                total++; if (mito_input !== exp) begin bad++; $display("FAIL tmo_word got=%0h want=%0h", mito_input, exp); end
            end
            if (timeout) begin tmo++; if (first < 0) first = c; end
            if (done) dn++;
        end
`ifdef MITO_FEEDER_TIMEOUT_EN
        total++; if (tmo !== 1) begin bad++; $display("FAIL tmo_pulses got=%0d want=1", tmo); end
        total++; if (first !== 10) begin bad++; $display("FAIL tmo_cycle got=%0d want=10", first); end
        total++; if (dn !== 0) begin bad++; $display("FAIL tmo_done got=%0d want=0", dn); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle got=%0b want=0", busy); end
`else
        total++; if (tmo !== 0) begin bad++; $display("FAIL tmo_pulses got=%0d want=0", tmo); end
        total++; if (dn !== 0) begin bad++; $display("FAIL tmo_done got=%0d want=0", dn); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_waiting got=%0b want=1", busy); end
        mito_ready_finish = 1'b1;
        @(negedge clk);
        mito_ready_finish = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL tmo_late_done got=%0b want=1", done); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        host_wr_valid = 1'b0;
        host_wr_data = '0;
        launch = 1'b0;
        launch_len = '0;
        mito_ready_finish = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_underrun();
        test_edge();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
